// File: rtl/k005297_pkg.sv
// Shared types for the K005297 bubble command arbiter.
package k005297_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    GRANT   = 3'd1,
    ISSUE   = 3'd2,
    BUSY    = 3'd3,
    DONE    = 3'd4,
    ERR     = 3'd5,
    ERRDONE = 3'd6
  } arb_state_t;

  localparam logic REQ_HOST = 1'b0;
  localparam logic REQ_BOOT = 1'b1;

  function automatic logic [1:0] onehot2(input logic id);
    return (id == REQ_BOOT) ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/k005297_rr_pick.sv
// Two-way round-robin picker: a lone requester wins, a tie goes to the one that did not win last.
module k005297_rr_pick
  import k005297_pkg::*;
(
  input  logic [1:0] i_req,
  input  logic       i_last,
  output logic       o_valid,
  output logic       o_id
);

  assign o_valid = |i_req;
  assign o_id    = (&i_req) ? ~i_last : i_req[REQ_BOOT];

endmodule

// File: rtl/k005297_cmd_arbiter.sv
// Arbitrates the K005297 bubble R/W command register between host (0) and boot (1) ports.
// Optional watchdog on ISSUE/BUSY enabled with `define K005297_ARB_WATCHDOG_EN.
//
//  state   | meaning
//  --------+-------------------------------------------------
//  IDLE    | no owner, waiting for any request
//  GRANT   | o_ACK pulse to the winner, operands latched
//  ISSUE   | RDREQ/WRREQ driven until the FSM clears CMDREG
//  BUSY    | waiting for a rising edge of i_OP_DONE
//  DONE    | o_DONE pulse to the owner
//  ERR     | system error (or timeout), requests forced low
//  ERRDONE | o_DONE pulse to the owner with o_ERR high
module k005297_cmd_arbiter
  import k005297_pkg::*;
#(
  parameter int PAGE_W    = 12,
  parameter int TIMEOUT_W = 16
) (
  input  logic                i_MCLK,
  input  logic                i_RST_n,
  input  logic                i_CLK2M_PCEN_n,
  input  logic [1:0]          i_REQ,
  input  logic [1:0]          i_REQ_WR,
  input  logic [2*PAGE_W-1:0] i_REQ_PAGE,
  output logic [1:0]          o_ACK,
  output logic [1:0]          o_DONE,
  output logic                o_ERR,
  output logic                o_BUSY,
  output logic                o_GRANT_ID,
  output logic [PAGE_W-1:0]   o_PAGE,
  output logic                o_CMDREG_RDREQ,
  output logic                o_CMDREG_WRREQ,
  input  logic                i_CMDREG_RST_n,
  input  logic                i_OP_DONE,
  input  logic                i_SYS_ERR_FLAG
);

  arb_state_t r_state;
  logic       r_rr_last;
  logic       r_wr;
  logic       r_op_done_q;

  logic              w_valid;
  logic              w_id;
  logic [PAGE_W-1:0] w_page;
  logic              w_op_done_rise;
  logic              w_wd_tc;
  logic              w_en;

  assign w_en           = ~i_CLK2M_PCEN_n;
  assign w_page         = w_id ? i_REQ_PAGE[2*PAGE_W-1:PAGE_W] : i_REQ_PAGE[PAGE_W-1:0];
  assign w_op_done_rise = i_OP_DONE & ~r_op_done_q;

  k005297_rr_pick u_pick (
    .i_req   (i_REQ),
    .i_last  (r_rr_last),
    .o_valid (w_valid),
    .o_id    (w_id)
  );

`ifdef K005297_ARB_WATCHDOG_EN
  logic [TIMEOUT_W-1:0] r_wd_cnt;
  logic [TIMEOUT_W-1:0] w_wd_next;

  assign w_wd_next = r_wd_cnt + 1'b1;
  // Expires on the cycle whose increment would reach the terminal count.
  assign w_wd_tc   = ((r_state == ISSUE) || (r_state == BUSY)) && (w_wd_next == '1);

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_wd_cnt <= '0;
    end else if (w_en) begin
      if (r_state == GRANT) begin
        r_wd_cnt <= '0;
      end else if ((r_state == ISSUE) || (r_state == BUSY)) begin
        r_wd_cnt <= w_wd_next;
      end
    end
  end
`else
  assign w_wd_tc = 1'b0;
`endif

  always_ff @(posedge i_MCLK or negedge i_RST_n) begin
    if (!i_RST_n) begin
      r_state        <= IDLE;
      r_rr_last      <= REQ_BOOT;
      r_wr           <= 1'b0;
      r_op_done_q    <= 1'b0;
      o_ACK          <= 2'b00;
      o_DONE         <= 2'b00;
      o_ERR          <= 1'b0;
      o_BUSY         <= 1'b0;
      o_GRANT_ID     <= 1'b0;
      o_PAGE         <= '0;
      o_CMDREG_RDREQ <= 1'b0;
      o_CMDREG_WRREQ <= 1'b0;
    end else if (w_en) begin
      r_op_done_q <= i_OP_DONE;
      o_ACK       <= 2'b00;
      o_DONE      <= 2'b00;
      case (r_state)
        IDLE: begin
          if (w_valid) begin
            r_state    <= GRANT;
            o_ACK      <= onehot2(w_id);
            o_BUSY     <= 1'b1;
            o_GRANT_ID <= w_id;
            o_PAGE     <= w_page;
            r_wr       <= i_REQ_WR[w_id];
          end
        end
        GRANT: begin
          r_state        <= ISSUE;
          o_CMDREG_RDREQ <= ~r_wr;
          o_CMDREG_WRREQ <= r_wr;
        end
        ISSUE: begin
          // Error beats a simultaneous CMDREG clear strobe.
          if (i_SYS_ERR_FLAG || w_wd_tc) begin
            r_state        <= ERR;
            o_ERR          <= 1'b1;
            o_CMDREG_RDREQ <= 1'b0;
            o_CMDREG_WRREQ <= 1'b0;
          end else if (!i_CMDREG_RST_n) begin
            r_state        <= BUSY;
            o_CMDREG_RDREQ <= 1'b0;
            o_CMDREG_WRREQ <= 1'b0;
          end
        end
        BUSY: begin
          if (i_SYS_ERR_FLAG) begin
            r_state <= ERR;
            o_ERR   <= 1'b1;
          end else if (w_op_done_rise) begin
            r_state <= DONE;
            o_DONE  <= onehot2(o_GRANT_ID);
          end else if (w_wd_tc) begin
            r_state <= ERR;
            o_ERR   <= 1'b1;
          end
        end
        DONE: begin
          r_state   <= IDLE;
          r_rr_last <= o_GRANT_ID;
          o_BUSY    <= 1'b0;
        end
        ERR: begin
          if (!i_SYS_ERR_FLAG) begin
            r_state <= ERRDONE;
            o_DONE  <= onehot2(o_GRANT_ID);
          end
        end
        ERRDONE: begin
          r_state   <= IDLE;
          r_rr_last <= o_GRANT_ID;
          o_ERR     <= 1'b0;
          o_BUSY    <= 1'b0;
        end
        default: begin
          r_state        <= IDLE;
          o_ERR          <= 1'b0;
          o_BUSY         <= 1'b0;
          o_CMDREG_RDREQ <= 1'b0;
          o_CMDREG_WRREQ <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_k005297_cmd_arbiter.sv
// Self-checking bench for k005297_cmd_arbiter; define K005297_ARB_WATCHDOG_EN to cover the watchdog.
module tb_k005297_cmd_arbiter;

  localparam int PAGE_W = 12;

  logic                i_MCLK = 1'b0;
  logic                i_RST_n = 1'b0;
  logic                i_CLK2M_PCEN_n = 1'b1;
  logic [1:0]          i_REQ = 2'b00;
  logic [1:0]          i_REQ_WR = 2'b00;
  logic [2*PAGE_W-1:0] i_REQ_PAGE = '0;
  logic                i_CMDREG_RST_n = 1'b1;
  logic                i_OP_DONE = 1'b0;
  logic                i_SYS_ERR_FLAG = 1'b0;
  logic [1:0]          o_ACK;
  logic [1:0]          o_DONE;
  logic                o_ERR;
  logic                o_BUSY;
  logic                o_GRANT_ID;
  logic [PAGE_W-1:0]   o_PAGE;
  logic                o_CMDREG_RDREQ;
  logic                o_CMDREG_WRREQ;

  k005297_cmd_arbiter #(.PAGE_W(PAGE_W), .TIMEOUT_W(4)) dut (
    .i_MCLK         (i_MCLK),
    .i_RST_n        (i_RST_n),
    .i_CLK2M_PCEN_n (i_CLK2M_PCEN_n),
    .i_REQ          (i_REQ),
    .i_REQ_WR       (i_REQ_WR),
    .i_REQ_PAGE     (i_REQ_PAGE),
    .o_ACK          (o_ACK),
    .o_DONE         (o_DONE),
    .o_ERR          (o_ERR),
    .o_BUSY         (o_BUSY),
    .o_GRANT_ID     (o_GRANT_ID),
    .o_PAGE         (o_PAGE),
    .o_CMDREG_RDREQ (o_CMDREG_RDREQ),
    .o_CMDREG_WRREQ (o_CMDREG_WRREQ),
    .i_CMDREG_RST_n (i_CMDREG_RST_n),
    .i_OP_DONE      (i_OP_DONE),
    .i_SYS_ERR_FLAG (i_SYS_ERR_FLAG)
  );

  always #5 i_MCLK = ~i_MCLK;

  typedef struct packed {
    logic [1:0]  ack;
    logic [1:0]  done;
    logic        err;
    logic        busy;
    logic        gid;
    logic [11:0] page;
    logic        rd;
    logic        wr;
  } out_t;

  typedef struct {
    string       name;
    logic [1:0]  req;
    logic [1:0]  wr;
    logic [11:0] p0;
    logic [11:0] p1;
    logic        crst;
    logic        od;
    logic        se;
    out_t        exp;
  } vec_t;

  vec_t vecs[$];
  out_t sb[$];
  int   checks = 0;
  int   errors = 0;
  logic both_seen = 1'b0;

  always @(negedge i_MCLK) if (o_CMDREG_RDREQ && o_CMDREG_WRREQ) both_seen <= 1'b1;

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish within 200000 time units");
    $fatal(1);
  end

  function automatic out_t mk(input logic [1:0] ack, input logic [1:0] done, input logic err,
                              input logic busy, input logic gid, input logic [11:0] page,
                              input logic rd, input logic wr);
    out_t o;
    o.ack = ack; o.done = done; o.err = err; o.busy = busy;
    o.gid = gid; o.page = page; o.rd = rd; o.wr = wr;
    return o;
  endfunction

  function automatic out_t cur();
    return mk(o_ACK, o_DONE, o_ERR, o_BUSY, o_GRANT_ID, o_PAGE, o_CMDREG_RDREQ, o_CMDREG_WRREQ);
  endfunction

  task automatic cmp(input string name, input out_t got, input out_t exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got ack=%b done=%b err=%b busy=%b gid=%b page=%h rd=%b wr=%b, required ack=%b done=%b err=%b busy=%b gid=%b page=%h rd=%b wr=%b",
               name, got.ack, got.done, got.err, got.busy, got.gid, got.page, got.rd, got.wr,
               exp.ack, exp.done, exp.err, exp.busy, exp.gid, exp.page, exp.rd, exp.wr);
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h required %h", name, got, exp);
    end
  endtask

  task automatic add(input string name, input logic [1:0] req, input logic [1:0] wr,
                     input logic [11:0] p0, input logic [11:0] p1, input logic crst,
                     input logic od, input logic se, input out_t exp);
    vec_t v;
    v.name = name; v.req = req; v.wr = wr; v.p0 = p0; v.p1 = p1;
    v.crst = crst; v.od = od; v.se = se; v.exp = exp;
    vecs.push_back(v);
  endtask

  task automatic en_edge();
    @(negedge i_MCLK) i_CLK2M_PCEN_n = 1'b0;
    @(posedge i_MCLK) #1;
  endtask

  task automatic hold_edge();
    @(negedge i_MCLK) i_CLK2M_PCEN_n = 1'b1;
    @(posedge i_MCLK) #1;
  endtask

  task automatic step();
    en_edge();
    hold_edge();
  endtask

  // Outputs are checked after the enable edge and again after a disabled edge (must hold).
  task automatic apply(input vec_t v);
    out_t e;
    i_REQ = v.req; i_REQ_WR = v.wr; i_REQ_PAGE = {v.p1, v.p0};
    i_CMDREG_RST_n = v.crst; i_OP_DONE = v.od; i_SYS_ERR_FLAG = v.se;
    sb.push_back(v.exp);
    en_edge();
    e = sb.pop_front();
    cmp(v.name, cur(), e);
    hold_edge();
    cmp({v.name, "_hold"}, cur(), e);
  endtask

  task automatic do_reset();
    i_RST_n = 1'b0;
    i_REQ = 2'b00; i_REQ_WR = 2'b00; i_REQ_PAGE = '0;
    i_CMDREG_RST_n = 1'b1; i_OP_DONE = 1'b0; i_SYS_ERR_FLAG = 1'b0;
    repeat (2) @(posedge i_MCLK);
    @(negedge i_MCLK) i_RST_n = 1'b1;
    #1;
  endtask

  initial begin
    logic ok;
    do_reset();
    cmp("reset", cur(), mk(2'b00, 2'b00, 0, 0, 0, 12'h000, 0, 0));

    // Host read of page 0A5, request dropped right after ACK.
    add("A_grant",    2'b01, 2'b00, 12'h0A5, 12'h000, 1, 0, 0, mk(2'b01, 2'b00, 0, 1, 0, 12'h0A5, 0, 0));
    add("A_issue",    2'b00, 2'b00, 12'h0A5, 12'h000, 1, 0, 0, mk(2'b00, 2'b00, 0, 1, 0, 12'h0A5, 1, 0));
    add("A_issue2",   2'b00, 2'b00, 12'h000, 12'h000, 1, 0, 0, mk(2'b00, 2'b00, 0, 1, 0, 12'h0A5, 1, 0));
    add("A_strobe",   2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 0, mk(2'b00, 2'b00, 0, 1, 0, 12'h0A5, 0, 0));
    add("A_busy",     2'b00, 2'b00, 12'h000, 12'h000, 1, 0, 0, mk(2'b00, 2'b00, 0, 1, 0, 12'h0A5, 0, 0));
    add("A_done",     2'b00, 2'b00, 12'h000, 12'h000, 1, 1, 0, mk(2'b00, 2'b01, 0, 1, 0, 12'h0A5, 0, 0));
    add("A_idle",     2'b00, 2'b00, 12'h000, 12'h000, 1, 1, 0, mk(2'b00, 2'b00, 0, 0, 0, 12'h0A5, 0, 0));
    // Boot read of page 3C3, system error for 5 cycles in BUSY.
    add("B_grant",    2'b10, 2'b00, 12'h777, 12'h3C3, 1, 0, 0, mk(2'b10, 2'b00, 0, 1, 1, 12'h3C3, 0, 0));
    add("B_issue",    2'b10, 2'b00, 12'h777, 12'h3C3, 1, 0, 0, mk(2'b00, 2'b00, 0, 1, 1, 12'h3C3, 1, 0));
    add("B_strobe",   2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 0, mk(2'b00, 2'b00, 0, 1, 1, 12'h3C3, 0, 0));
    add("B_err1",     2'b00, 2'b00, 12'h000, 12'h000, 1, 0, 1, mk(2'b00, 2'b00, 1, 1, 1, 12'h3C3, 0, 0));
    for (int i = 2; i <= 5; i++)
      add($sformatf("B_err%0d", i), 2'b00, 2'b00, 12'h000, 12'h000, 1, 0, 1, mk(2'b00, 2'b00, 1, 1, 1, 12'h3C3, 0, 0));
    add("B_errdone",  2'b00, 2'b00, 12'h000, 12'h000, 1, 0, 0, mk(2'b00, 2'b10, 1, 1, 1, 12'h3C3, 0, 0));
    add("B_idle",     2'b00, 2'b00, 12'h000, 12'h000, 1, 0, 0, mk(2'b00, 2'b00, 0, 0, 1, 12'h3C3, 0, 0));
    // Host write granted with error flag already high; error beats the strobe.
    add("C_grant",    2'b01, 2'b01, 12'h111, 12'h222, 1, 0, 1, mk(2'b01, 2'b00, 0, 1, 0, 12'h111, 0, 0));
    add("C_issue",    2'b00, 2'b00, 12'h000, 12'h000, 1, 0, 1, mk(2'b00, 2'b00, 0, 1, 0, 12'h111, 0, 1));
    add("C_err_win",  2'b00, 2'b00, 12'h000, 12'h000, 0, 0, 1, mk(2'b00, 2'b00, 1, 1, 0, 12'h111, 0, 0));
    add("C_errdone",  2'b00, 2'b00, 12'h000, 12'h000, 1, 0, 0, mk(2'b00, 2'b01, 1, 1, 0, 12'h111, 0, 0));
    add("C_idle",     2'b00, 2'b00, 12'h000, 12'h000, 1, 0, 0, mk(2'b00, 2'b00, 0, 0, 0, 12'h111, 0, 0));

    foreach (vecs[i]) apply(vecs[i]);

    // Both requesters hold REQ with writes: strict alternation from reset.
    do_reset();
    i_REQ = 2'b11; i_REQ_WR = 2'b11; i_REQ_PAGE = {12'h002, 12'h001};
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("D%0d_ack", k), {30'd0, o_ACK}, (k % 2) ? 32'd2 : 32'd1);
      chk($sformatf("D%0d_page", k), {20'd0, o_PAGE}, (k % 2) ? 32'h002 : 32'h001);
      step();
      chk($sformatf("D%0d_rdwr", k), {30'd0, o_CMDREG_RDREQ, o_CMDREG_WRREQ}, 32'd1);
      i_CMDREG_RST_n = 1'b0; step(); i_CMDREG_RST_n = 1'b1;
      i_OP_DONE = 1'b1; step();
      chk($sformatf("D%0d_done", k), {30'd0, o_DONE}, (k % 2) ? 32'd2 : 32'd1);
      if (k == 3) i_REQ = 2'b00;
      i_OP_DONE = 1'b0; step();
    end
    chk("D_never_both", {31'd0, both_seen}, 32'd0);

    // OP_DONE already high when BUSY is entered.
    i_OP_DONE = 1'b1; i_REQ = 2'b01; i_REQ_WR = 2'b00; i_REQ_PAGE = {12'h000, 12'h0A0};
    step(); i_REQ = 2'b00;
    step();
    i_CMDREG_RST_n = 1'b0; step(); i_CMDREG_RST_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      chk($sformatf("E_level%0d", k), {30'd0, o_DONE, o_BUSY}, 32'd1);
    end
    i_OP_DONE = 1'b0; step();
    chk("E_fall", {30'd0, o_DONE, o_BUSY}, 32'd1);
    i_OP_DONE = 1'b1; step();
    chk("E_rise", {30'd0, o_DONE}, 32'd1);
    step();
    chk("E_idle", {31'd0, o_BUSY}, 32'd0);

    // Async reset while in ISSUE.
    i_REQ = 2'b10; step(); i_REQ = 2'b00;
    step();
    chk("F_issue", {31'd0, o_CMDREG_RDREQ}, 32'd1);
    #2 i_RST_n = 1'b0;
    #1 cmp("F_async", cur(), mk(2'b00, 2'b00, 0, 0, 0, 12'h000, 0, 0));
    en_edge();
    cmp("F_held", cur(), mk(2'b00, 2'b00, 0, 0, 0, 12'h000, 0, 0));
    i_RST_n = 1'b1;
    hold_edge();
    i_REQ = 2'b11; i_REQ_PAGE = {12'h0B1, 12'h0B0};
    step();
    chk("F_first_grant", {30'd0, o_ACK}, 32'd1);
    i_REQ = 2'b00; step();
    i_CMDREG_RST_n = 1'b0; step(); i_CMDREG_RST_n = 1'b1;
    i_OP_DONE = 1'b0; step();
    i_OP_DONE = 1'b1; step();
    chk("F_done", {30'd0, o_DONE}, 32'd1);
    step();

    // No CMDREG strobe: watchdog (TIMEOUT_W=4) or indefinite wait.
    i_OP_DONE = 1'b0; i_REQ = 2'b01; i_REQ_WR = 2'b00;
    step(); i_REQ = 2'b00;
    step();
    ok = 1'b1;
    for (int k = 0; k < 14; k++) begin
      step();
      if (!(o_CMDREG_RDREQ === 1'b1 && o_ERR === 1'b0)) ok = 1'b0;
    end
    chk("G_issue_14", {31'd0, ok}, 32'd1);
`ifdef K005297_ARB_WATCHDOG_EN
    step();
    chk("G_wd_err", {29'd0, o_ERR, o_BUSY, o_CMDREG_RDREQ}, 32'd6);
    step();
    chk("G_wd_errdone", {29'd0, o_DONE, o_ERR}, 32'd3);
    step();
    chk("G_wd_idle", {30'd0, o_ERR, o_BUSY}, 32'd0);
`else
    repeat (30) step();
    chk("G_no_wd", {29'd0, o_ERR, o_BUSY, o_CMDREG_RDREQ}, 32'd3);
    i_CMDREG_RST_n = 1'b0; step(); i_CMDREG_RST_n = 1'b1;
    step();
    i_OP_DONE = 1'b1; step();
    chk("G_done", {30'd0, o_DONE}, 32'd1);
    step();
    chk("G_idle", {31'd0, o_BUSY}, 32'd0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
